// File: rtl/bin_sequencer.sv
// ============================================================================
// Module      : bin_sequencer
// Description : Accepts decode commands (context state, bypass flag, bin
//               count) and steps an external arithmetic Decoder one decode
//               cycle at a time. In bypass mode it requests up to BIN_WIDTH
//               bins per step. Each step's bins go to a valid/ready output
//               stage that stalls decoding under backpressure.
//               Optional build macro SEQ_STATS_EN adds the stat_cmds and
//               stat_bins counters and their output ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_sequencer #(
   parameter int BIN_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [7:0]           cmd_pstate,
   input  logic                 cmd_bypass,
   input  logic [6:0]           cmd_numbins,
   output logic [7:0]           pState_in,
   output logic                 bypass,
   output logic [1:0]           n_bin,
   output logic                 dec_en,
   input  logic [BIN_WIDTH-1:0] bin,
   output logic [BIN_WIDTH-1:0] out_bins,
   output logic [2:0]           out_cnt,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef SEQ_STATS_EN
   ,
   output logic [15:0]          stat_cmds,
   output logic [23:0]          stat_bins
`endif
);

   // BIN_WIDTH widened to the remaining-counter width, and the largest n_bin
   localparam logic [6:0] c_BW7    = 7'(BIN_WIDTH);
   localparam logic [1:0] c_NB_MAX = 2'(BIN_WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [6:0]  r_remaining;
   logic [6:0]  w_rem_nxt;
   logic [2:0]  w_step;
   logic        w_accept;

   // Bins requested this step: one for regular bins, otherwise as many as
   // remain up to BIN_WIDTH. Below BIN_WIDTH (<= 4) remaining fits in 2 bits.
   always_comb begin
      n_bin = 2'd0;
      if (r_state == S_RUN && bypass) begin
         if (r_remaining >= c_BW7) begin
            n_bin = c_NB_MAX;
         end else begin
            n_bin = r_remaining[1:0] - 2'd1;
         end
      end
   end

   assign w_step    = {1'b0, n_bin} + 3'd1;
   assign w_rem_nxt = r_remaining - {4'd0, w_step};

   // Next-state, command handshake and decode-step enable
   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      dec_en      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_accept = 1'b1;
               // A zero-bin command is consumed without any decode step
               if (cmd_numbins != 7'd0) begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            // Decode only when the output slot is free or being drained
            dec_en = !out_valid || out_ready;
            if (dec_en && w_rem_nxt == 7'd0) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Command context, held for the whole command; remaining bin counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pState_in   <= 8'd0;
         bypass      <= 1'b0;
         r_remaining <= 7'd0;
      end else if (w_accept) begin
         pState_in   <= cmd_pstate;
         bypass      <= cmd_bypass;
         r_remaining <= cmd_numbins;
      end else if (dec_en) begin
         r_remaining <= w_rem_nxt;
      end
   end

   // Output stage: a new step overwrites the slot without a bubble,
   // otherwise the slot holds until the consumer takes it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_bins  <= '0;
         out_cnt   <= 3'd0;
         out_valid <= 1'b0;
      end else if (dec_en) begin
         out_bins  <= bin;
         out_cnt   <= w_step;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef SEQ_STATS_EN
   // Free-running wrap-around usage counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_cmds <= 16'd0;
         stat_bins <= 24'd0;
      end else begin
         if (w_accept) begin
            stat_cmds <= stat_cmds + 16'd1;
         end
         if (dec_en) begin
            stat_bins <= stat_bins + {21'd0, w_step};
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bin_sequencer.sv
// ============================================================================
// Module      : tb_bin_sequencer
// Description : Directed self-checking bench for bin_sequencer. The bench
//               plays the Decoder, supplying bins in each dec_en cycle.
//               Define SEQ_STATS_EN to also check the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_sequencer;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_pstate;
   logic       cmd_bypass;
   logic [6:0] cmd_numbins;
   logic [7:0] pState_in;
   logic       bypass;
   logic [1:0] n_bin;
   logic       dec_en;
   logic [3:0] bin;
   logic [3:0] out_bins;
   logic [2:0] out_cnt;
   logic       out_valid;
   logic       out_ready;
`ifdef SEQ_STATS_EN
   logic [15:0] stat_cmds;
   logic [23:0] stat_bins;
`endif

   int errors = 0;
   int checks = 0;

   bin_sequencer #(.BIN_WIDTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_pstate  (cmd_pstate),
      .cmd_bypass  (cmd_bypass),
      .cmd_numbins (cmd_numbins),
      .pState_in   (pState_in),
      .bypass      (bypass),
      .n_bin       (n_bin),
      .dec_en      (dec_en),
      .bin         (bin),
      .out_bins    (out_bins),
      .out_cnt     (out_cnt),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
`ifdef SEQ_STATS_EN
      ,
      .stat_cmds   (stat_cmds),
      .stat_bins   (stat_bins)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one command for exactly one posedge; caller starts at a negedge
   task automatic issue_cmd(input logic [7:0] ps, input logic byp, input logic [6:0] nb);
      cmd_pstate  = ps;
      cmd_bypass  = byp;
      cmd_numbins = nb;
      cmd_valid   = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd_valid = 1'b0; cmd_pstate = 8'h00; cmd_bypass = 1'b0;
      cmd_numbins = 7'd0; bin = 4'h0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0 || out_bins !== 4'h0 || out_cnt !== 3'd0) begin
         errors++; $display("FAIL reset_out: got v=%b bins=%h cnt=%0d want 0/0/0", out_valid, out_bins, out_cnt); end
      checks++; if (pState_in !== 8'h00 || bypass !== 1'b0) begin
         errors++; $display("FAIL reset_ctx: got ps=%h byp=%b want 00/0", pState_in, bypass); end
      checks++; if (dec_en !== 1'b0 || n_bin !== 2'd0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ctl: got dec_en=%b n_bin=%0d rdy=%b want 0/0/1", dec_en, n_bin, cmd_ready); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_regular();
      logic [2:0] bits;
      bits = 3'b101;
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reg_idle_ready: got %b want 1", cmd_ready); end
      issue_cmd(8'h2A, 1'b0, 7'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bin = {3'b000, bits[i]};
         #1;
         checks++; if (dec_en !== 1'b1 || n_bin !== 2'd0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reg_step%0d_ctl: got dec_en=%b n_bin=%0d rdy=%b want 1/0/0", i, dec_en, n_bin, cmd_ready); end
         checks++; if (pState_in !== 8'h2A || bypass !== 1'b0) begin
            errors++; $display("FAIL reg_step%0d_ctx: got ps=%h byp=%b want 2a/0", i, pState_in, bypass); end
         if (i > 0) begin
            checks++; if (out_valid !== 1'b1 || out_bins !== {3'b000, bits[i-1]} || out_cnt !== 3'd1) begin
               errors++; $display("FAIL reg_out%0d: got v=%b bins=%h cnt=%0d want 1/%h/1", i-1, out_valid, out_bins, out_cnt, bits[i-1]); end
         end
      end
      @(negedge clk);
      bin = 4'h0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_bins !== 4'h1 || out_cnt !== 3'd1) begin
         errors++; $display("FAIL reg_out2: got v=%b bins=%h cnt=%0d want 1/1/1", out_valid, out_bins, out_cnt); end
      checks++; if (dec_en !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reg_back_idle: got dec_en=%b rdy=%b want 0/1", dec_en, cmd_ready); end
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reg_drain: got out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_bypass();
      logic [9:0]  stream;
      logic [3:0]  bv  [3];
      logic [1:0]  nbv [3];
      logic [2:0]  cv  [3];
      logic [11:0] got;
      int          pos;
      stream = 10'h2C6;
      bv  = '{4'h6, 4'hC, 4'h2};
      nbv = '{2'd3, 2'd3, 2'd1};
      cv  = '{3'd4, 3'd4, 3'd2};
      got = '0;
      pos = 0;
      @(negedge clk);
      out_ready = 1'b1;
      issue_cmd(8'h3C, 1'b1, 7'd10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bin = (i < 3) ? bv[i] : 4'h0;
         #1;
         if (i < 3) begin
            checks++; if (dec_en !== 1'b1 || n_bin !== nbv[i] || bypass !== 1'b1) begin
               errors++; $display("FAIL byp_step%0d: got dec_en=%b n_bin=%0d byp=%b want 1/%0d/1", i, dec_en, n_bin, bypass, nbv[i]); end
         end else begin
            checks++; if (dec_en !== 1'b0 || cmd_ready !== 1'b1) begin
               errors++; $display("FAIL byp_back_idle: got dec_en=%b rdy=%b want 0/1", dec_en, cmd_ready); end
         end
         if (i > 0) begin
            checks++; if (out_valid !== 1'b1 || out_cnt !== cv[i-1] || out_bins !== bv[i-1]) begin
               errors++; $display("FAIL byp_out%0d: got v=%b bins=%h cnt=%0d want 1/%h/%0d", i-1, out_valid, out_bins, out_cnt, bv[i-1], cv[i-1]); end
            for (int b = 0; b < 4; b++) begin
               if (b < int'(out_cnt) && pos + b < 12) got[pos+b] = out_bins[b];
            end
            pos += int'(out_cnt);
         end
      end
      checks++; if (pos != 10 || got[9:0] !== stream) begin
         errors++; $display("FAIL byp_stream: got %0d bins %h want 10 bins %h", pos, got[9:0], stream); end
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL byp_drain: got out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_zero_bins();
      @(negedge clk);
      #1;
      checks++; if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL zero_ready_pre: got %b want 1", cmd_ready); end
      issue_cmd(8'h10, 1'b1, 7'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++; if (dec_en !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_idle%0d: got dec_en=%b rdy=%b v=%b want 0/1/0", i, dec_en, cmd_ready, out_valid); end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 1'b1;
      issue_cmd(8'h55, 1'b1, 7'd8);
      @(negedge clk);
      bin = 4'hA;
      #1;
      checks++; if (dec_en !== 1'b1 || n_bin !== 2'd3) begin
         errors++; $display("FAIL bp_first: got dec_en=%b n_bin=%0d want 1/3", dec_en, n_bin); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         out_ready = 1'b0;
         bin = 4'hF;
         #1;
         checks++; if (dec_en !== 1'b0 || out_valid !== 1'b1 || out_bins !== 4'hA || out_cnt !== 3'd4) begin
            errors++; $display("FAIL bp_hold%0d: got dec_en=%b v=%b bins=%h cnt=%0d want 0/1/a/4", k, dec_en, out_valid, out_bins, out_cnt); end
      end
      @(negedge clk);
      out_ready = 1'b1;
      bin = 4'h5;
      #1;
      checks++; if (dec_en !== 1'b1 || n_bin !== 2'd3 || out_bins !== 4'hA) begin
         errors++; $display("FAIL bp_resume: got dec_en=%b n_bin=%0d bins=%h want 1/3/a", dec_en, n_bin, out_bins); end
      @(negedge clk);
      bin = 4'h0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_bins !== 4'h5 || out_cnt !== 3'd4 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL bp_last: got v=%b bins=%h cnt=%0d rdy=%b want 1/5/4/1", out_valid, out_bins, out_cnt, cmd_ready); end
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain: got out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      out_ready = 1'b1;
      issue_cmd(8'h77, 1'b1, 7'd20);
      @(negedge clk);
      bin = 4'h3;
      @(negedge clk);
      bin = 4'h9;
      #1;
      checks++; if (out_valid !== 1'b1 || out_bins !== 4'h3 || dec_en !== 1'b1) begin
         errors++; $display("FAIL rst_mid_pre: got v=%b bins=%h dec_en=%b want 1/3/1", out_valid, out_bins, dec_en); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_bins !== 4'h0 || out_cnt !== 3'd0) begin
         errors++; $display("FAIL rst_mid_out: got v=%b bins=%h cnt=%0d want 0/0/0", out_valid, out_bins, out_cnt); end
      checks++; if (pState_in !== 8'h00 || bypass !== 1'b0 || n_bin !== 2'd0 || dec_en !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_ctl: got ps=%h byp=%b n_bin=%0d dec_en=%b rdy=%b want 00/0/0/0/1", pState_in, bypass, n_bin, dec_en, cmd_ready); end
      @(negedge clk);
      reset = 1'b0;
      issue_cmd(8'h11, 1'b1, 7'd3);
      @(negedge clk);
      bin = 4'h5;
      #1;
      checks++; if (dec_en !== 1'b1 || n_bin !== 2'd2 || pState_in !== 8'h11 || bypass !== 1'b1) begin
         errors++; $display("FAIL rst_next_step: got dec_en=%b n_bin=%0d ps=%h byp=%b want 1/2/11/1", dec_en, n_bin, pState_in, bypass); end
      @(negedge clk);
      bin = 4'h0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_bins !== 4'h5 || out_cnt !== 3'd3 || cmd_ready !== 1'b1 || dec_en !== 1'b0) begin
         errors++; $display("FAIL rst_next_out: got v=%b bins=%h cnt=%0d rdy=%b dec_en=%b want 1/5/3/1/0", out_valid, out_bins, out_cnt, cmd_ready, dec_en); end
      @(negedge clk);
   endtask

`ifdef SEQ_STATS_EN
   task automatic test_stats();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (stat_cmds !== 16'd0 || stat_bins !== 24'd0) begin
         errors++; $display("FAIL stats_reset: got cmds=%0d bins=%0d want 0/0", stat_cmds, stat_bins); end
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      bin = 4'h0;
      issue_cmd(8'h01, 1'b0, 7'd5);
      repeat (8) @(negedge clk);
      issue_cmd(8'h02, 1'b1, 7'd0);
      @(negedge clk);
      issue_cmd(8'h03, 1'b1, 7'd7);
      repeat (6) @(negedge clk);
      #1;
      checks++; if (stat_cmds !== 16'd3 || stat_bins !== 24'd12) begin
         errors++; $display("FAIL stats_count: got cmds=%0d bins=%0d want 3/12", stat_cmds, stat_bins); end
   endtask
`endif

   initial begin
      test_reset();
      test_regular();
      test_bypass();
      test_zero_bins();
      test_backpressure();
      test_reset_mid();
`ifdef SEQ_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against any unexpected stall of the stimulus sequence
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/bin_sequencer.md
BIN_SEQUENCER -- requirements
Module: bin_sequencer

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 4, max bins per bypass decode cycle (legal 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command word present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge.
REQ-006 SHALL have port cmd_pstate  input  8  context state for the command.
REQ-007 SHALL have port cmd_bypass  input  1  1 = bypass bins, 0 = regular bins.
REQ-008 SHALL have port cmd_numbins  input  7  bins to decode for the command (0..127).
REQ-009 SHALL have port pState_in  output  8  registered cmd_pstate driven to Decoder.
REQ-010 SHALL have port bypass  output  1  registered cmd_bypass driven to Decoder.
REQ-011 SHALL have port n_bin  output  2  bins-minus-one requested from Decoder this cycle.
REQ-012 SHALL have port dec_en  output  1  Decoder performs one decode step at the next posedge.
REQ-013 SHALL have port bin  input  BIN_WIDTH  Decoder bin result, LSB first, valid in dec_en cycle.
REQ-014 SHALL have port out_bins  output  BIN_WIDTH  captured bins, LSB = first bin.
REQ-015 SHALL have port out_cnt  output  3  number of valid bits in out_bins (1..BIN_WIDTH).
REQ-016 SHALL have port out_valid / out_ready  output / input  1 each  output handshake.

Function
REQ-017 SHALL implement states IDLE, RUN; cmd_ready = 1 only in IDLE.
REQ-018 SHALL, on accept in IDLE, register pstate/bypass, load remaining = cmd_numbins, go RUN; if cmd_numbins = 0, stay IDLE, no decode step.
REQ-019 SHALL assert dec_en = RUN && (!out_valid || out_ready).
REQ-020 SHALL drive n_bin = 0 when bypass = 0; else n_bin = min(remaining, BIN_WIDTH) - 1.
REQ-021 SHALL, on each dec_en posedge, capture bin into out_bins, set out_cnt = n_bin + 1, set out_valid, decrement remaining by n_bin + 1.
REQ-022 SHALL return to IDLE in the cycle after the step that makes remaining = 0; next command acceptable that cycle.
REQ-023 SHALL hold out_bins/out_cnt/out_valid stable while out_valid && !out_ready; clear out_valid when out_ready and no new step.
REQ-024 SHALL, on simultaneous out_ready and dec_en, replace output with new bins, out_valid stays 1 (no bubble).
REQ-025 SHALL keep pState_in, bypass stable for the whole command.
REQ-026 SHALL never decrement remaining below 0 (7-bit unsigned, n_bin clamp guarantees this).

Reset
REQ-027 SHALL on reset, at any time including mid-command, force IDLE, remaining = 0, pState_in = 0, bypass = 0, n_bin = 0, dec_en = 0, out_bins = 0, out_cnt = 0, out_valid = 0; partial command discarded.
REQ-028 SHALL accept a command in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with SEQ_STATS_EN defined, add outputs stat_cmds (16b, commands accepted) and stat_bins (24b, bins decoded), both wrapping, cleared by reset.
REQ-030 SHALL, without SEQ_STATS_EN, omit those ports and counters; all other behaviour identical.

Verification
REQ-031 SHALL cover: regular cmd pstate=0x2A numbins=3, out_ready=1 -> 3 dec_en cycles, n_bin=0, out_cnt=1 each, return IDLE.
REQ-032 SHALL cover: bypass numbins=10, BIN_WIDTH=4 -> steps n_bin=3,3,1; out_cnt=4,4,2; 10 bins total, order preserved.
REQ-033 SHALL cover: numbins=0 -> accepted, no dec_en, cmd_ready stays 1.
REQ-034 SHALL cover: bypass numbins=8, out_ready=0 for 5 cycles after first output -> dec_en=0, out_bins held, resumes on out_ready=1 without loss.
REQ-035 SHALL cover: reset asserted mid bypass numbins=20 -> all outputs zero immediately, next command decodes correctly.
REQ-036 SHALL cover (SEQ_STATS_EN): 3 commands numbins 5,0,7 -> stat_cmds=3, stat_bins=12.
